// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with branch/jump resolution.
// Resolves the taken decision and target in EX and registers them with the
// instruction. Redirect is a one-cycle pulse and TakenCount counts redirects.
// Every output comes straight from a flop.
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        ExValid,
  input  logic [31:0] ALUResult,
  input  logic        Zero,
  input  logic        Less,
  input  logic [31:0] ReadData2,
  input  logic [31:0] pc,
  input  logic [31:0] ImmGenOut,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Jalr,
  input  logic [2:0]  Funct3,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToReg,
  input  logic        RegWrite,
  input  logic [4:0]  Rd,
  output logic        MemValid,
  output logic [31:0] MemALUResult,
  output logic [31:0] MemWriteData,
  output logic [4:0]  MemRd,
  output logic        MemRegWrite,
  output logic        MemMemRead,
  output logic        MemMemWrite,
  output logic        MemMemToReg,
  output logic        Redirect,
  output logic [31:0] BranchTarget,
  output logic        TargetMisaligned,
  output logic [31:0] TakenCount
);

  logic        taken;
  logic        fire;
  logic [31:0] target;
  logic [31:0] link;

  // Branch condition decode. Less already carries the signed/unsigned choice
  // made upstream, so BLT/BLTU and BGE/BGEU share a term.
  always_comb begin
    taken = 1'b0;
    if (Jump) begin
      taken = 1'b1;
    end else if (Branch) begin
      case (Funct3)
        3'b000:         taken = Zero;
        3'b001:         taken = ~Zero;
        3'b100, 3'b110: taken = Less;
        3'b101, 3'b111: taken = ~Less;
        default:        taken = 1'b0;
      endcase
    end
  end

  // JALR clears bit 0 of the computed address; all others are pc-relative.
  assign target = (Jump && Jalr) ? {ALUResult[31:1], 1'b0} : pc + ImmGenOut;
  assign link   = pc + 32'd4;
  assign fire   = ExValid && taken;

  // Stage register: Flush beats Stall, Stall holds everything but drops the
  // redirect pulse so a held instruction never redirects twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MemValid         <= 1'b0;
      MemALUResult     <= '0;
      MemWriteData     <= '0;
      MemRd            <= '0;
      MemRegWrite      <= 1'b0;
      MemMemRead       <= 1'b0;
      MemMemWrite      <= 1'b0;
      MemMemToReg      <= 1'b0;
      Redirect         <= 1'b0;
      BranchTarget     <= '0;
      TargetMisaligned <= 1'b0;
      TakenCount       <= '0;
    end else if (Flush) begin
      MemValid    <= 1'b0;
      MemRegWrite <= 1'b0;
      MemMemRead  <= 1'b0;
      MemMemWrite <= 1'b0;
      MemMemToReg <= 1'b0;
      Redirect    <= 1'b0;
    end else if (Stall) begin
      Redirect <= 1'b0;
    end else begin
      MemValid         <= ExValid;
      MemALUResult     <= Jump ? link : ALUResult;
      MemWriteData     <= ReadData2;
      MemRd            <= Rd;
      MemRegWrite      <= RegWrite & ExValid;
      MemMemRead       <= MemRead  & ExValid;
      MemMemWrite      <= MemWrite & ExValid;
      MemMemToReg      <= MemToReg & ExValid;
      Redirect         <= fire;
      BranchTarget     <= target;
      TargetMisaligned <= |target[1:0];
      // Counted on the edge that raises Redirect, so the count already
      // includes the redirect currently being signalled.
      if (fire) TakenCount <= TakenCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: a behavioural model predicts the MEM slot
// from plain arithmetic; a negedge process compares it against the DUT and
// the stimulus thread pins the model with hand-computed literals.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall, Flush, ExValid, Zero, Less, Branch, Jump, Jalr;
  logic        MemRead, MemWrite, MemToReg, RegWrite;
  logic [31:0] ALUResult, ReadData2, pc, ImmGenOut;
  logic [2:0]  Funct3;
  logic [4:0]  Rd;
  logic        MemValid, MemRegWrite, MemMemRead, MemMemWrite, MemMemToReg;
  logic        Redirect, TargetMisaligned;
  logic [31:0] MemALUResult, MemWriteData, BranchTarget, TakenCount;
  logic [4:0]  MemRd;

  int checks = 0;
  int errors = 0;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .ExValid(ExValid),
    .ALUResult(ALUResult), .Zero(Zero), .Less(Less), .ReadData2(ReadData2),
    .pc(pc), .ImmGenOut(ImmGenOut), .Branch(Branch), .Jump(Jump), .Jalr(Jalr),
    .Funct3(Funct3), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .Rd(Rd),
    .MemValid(MemValid), .MemALUResult(MemALUResult),
    .MemWriteData(MemWriteData), .MemRd(MemRd), .MemRegWrite(MemRegWrite),
    .MemMemRead(MemMemRead), .MemMemWrite(MemMemWrite),
    .MemMemToReg(MemMemToReg), .Redirect(Redirect),
    .BranchTarget(BranchTarget), .TargetMisaligned(TargetMisaligned),
    .TakenCount(TakenCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid, m_regw, m_mr, m_mw, m_m2r, m_redir, m_mis;
  logic [31:0] m_alu, m_wd, m_tgt, m_cnt;
  logic [4:0]  m_rd;

  function automatic bit model_taken();
    if (Jump) return 1'b1;
    if (!Branch) return 1'b0;
    case (Funct3)
      3'd0: return Zero;          // BEQ
      3'd1: return !Zero;         // BNE
      3'd4, 3'd6: return Less;    // BLT/BLTU
      3'd5, 3'd7: return !Less;   // BGE/BGEU
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_target();
    if (Jump && Jalr) return ALUResult - (ALUResult % 2);
    return pc + ImmGenOut;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 0; m_regw <= 0; m_mr <= 0; m_mw <= 0; m_m2r <= 0;
      m_redir <= 0; m_mis <= 0; m_alu <= 0; m_wd <= 0; m_tgt <= 0;
      m_cnt <= 0; m_rd <= 0;
    end else if (Flush) begin
      m_valid <= 0; m_regw <= 0; m_mr <= 0; m_mw <= 0; m_m2r <= 0; m_redir <= 0;
    end else if (Stall) begin
      m_redir <= 0;
    end else begin
      m_valid <= ExValid;
      m_regw  <= ExValid && RegWrite;
      m_mr    <= ExValid && MemRead;
      m_mw    <= ExValid && MemWrite;
      m_m2r   <= ExValid && MemToReg;
      m_redir <= ExValid && model_taken();
      m_alu   <= Jump ? pc + 32'd4 : ALUResult;
      m_wd    <= ReadData2;
      m_rd    <= Rd;
      m_tgt   <= model_target();
      m_mis   <= (model_target() % 4) != 0;
      if (ExValid && model_taken()) m_cnt <= m_cnt + 32'd1;
    end
  end

  // Cycle-by-cycle comparison; data fields only matter for a real
  // instruction, target fields only while Redirect is high.
  always @(negedge clk) begin
    chk("MemValid", {31'b0, MemValid}, {31'b0, m_valid});
    chk("ctrl", {28'b0, MemRegWrite, MemMemRead, MemMemWrite, MemMemToReg},
        {28'b0, m_regw, m_mr, m_mw, m_m2r});
    chk("Redirect", {31'b0, Redirect}, {31'b0, m_redir});
    chk("TakenCount", TakenCount, m_cnt);
    if (m_valid) begin
      chk("MemALUResult", MemALUResult, m_alu);
      chk("MemWriteData", MemWriteData, m_wd);
      chk("MemRd", {27'b0, MemRd}, {27'b0, m_rd});
    end
    if (m_redir) begin
      chk("BranchTarget", BranchTarget, m_tgt);
      chk("TargetMisaligned", {31'b0, TargetMisaligned}, {31'b0, m_mis});
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    Stall = 0; Flush = 0; ExValid = 0; Zero = 0; Less = 0; Branch = 0;
    Jump = 0; Jalr = 0; MemRead = 0; MemWrite = 0; MemToReg = 0;
    RegWrite = 0; ALUResult = 0; ReadData2 = 0; pc = 0; ImmGenOut = 0;
    Funct3 = 0; Rd = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {funct3, zero, less, expected taken} for the branch table
  logic [5:0] br_tab [8] = '{
    {3'd1, 1'b0, 1'b0, 1'b1}, {3'd4, 1'b0, 1'b1, 1'b1},
    {3'd6, 1'b0, 1'b1, 1'b1}, {3'd7, 1'b0, 1'b1, 1'b0},
    {3'd2, 1'b1, 1'b1, 1'b0}, {3'd3, 1'b1, 1'b1, 1'b0},
    {3'd0, 1'b0, 1'b0, 1'b0}, {3'd1, 1'b1, 1'b0, 1'b0}
  };

  initial begin
    clr();
    rst = 1;
    repeat (2) step();
    chk("rst_MemValid", {31'b0, MemValid}, 32'd0);
    chk("rst_TakenCount", TakenCount, 32'd0);
    rst = 0;

    // plain ALU op
    ExValid = 1; ALUResult = 30; RegWrite = 1; Rd = 5;
    step();
    chk("alu_MemValid", {31'b0, MemValid}, 32'd1);
    chk("alu_MemALUResult", MemALUResult, 32'd30);
    chk("alu_MemRd", {27'b0, MemRd}, 32'd5);
    chk("alu_Redirect", {31'b0, Redirect}, 32'd0);

    // BEQ taken
    clr(); ExValid = 1; Branch = 1; Funct3 = 3'b000; Zero = 1;
    pc = 32'h100; ImmGenOut = 32'h20;
    step();
    chk("beq_Redirect", {31'b0, Redirect}, 32'd1);
    chk("beq_Target", BranchTarget, 32'h120);
    chk("beq_Count", TakenCount, 32'd1);
    clr();
    step();
    chk("beq_pulse_end", {31'b0, Redirect}, 32'd0);

    // BGE not taken
    ExValid = 1; Branch = 1; Funct3 = 3'b101; Less = 1;
    step();
    chk("bge_Redirect", {31'b0, Redirect}, 32'd0);

    // JALR to a misaligned address
    clr(); ExValid = 1; Jump = 1; Jalr = 1; ALUResult = 32'h203;
    pc = 32'h40; RegWrite = 1; Rd = 1;
    step();
    chk("jalr_Target", BranchTarget, 32'h202);
    chk("jalr_Misaligned", {31'b0, TargetMisaligned}, 32'd1);
    chk("jalr_Link", MemALUResult, 32'h44);
    chk("jalr_Count", TakenCount, 32'd2);

    // JAL captured, then held by Stall with different EX inputs
    clr(); ExValid = 1; Jump = 1; pc = 32'h80; ImmGenOut = 32'h10;
    RegWrite = 1; Rd = 3;
    step();
    chk("jal_Redirect", {31'b0, Redirect}, 32'd1);
    chk("jal_Count", TakenCount, 32'd3);
    clr(); Stall = 1; ExValid = 1; Branch = 1; Zero = 1; ALUResult = 32'hdead;
    Rd = 7; pc = 32'h500;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_Redirect", {31'b0, Redirect}, 32'd0);
      chk("stall_Link", MemALUResult, 32'h84);
      chk("stall_Rd", {27'b0, MemRd}, 32'd3);
      chk("stall_Target", BranchTarget, 32'h90);
      chk("stall_Count", TakenCount, 32'd3);
    end

    // Flush and Stall together on a valid store
    clr(); Stall = 1; Flush = 1; ExValid = 1; MemWrite = 1; ReadData2 = 32'h55;
    step();
    chk("flush_MemValid", {31'b0, MemValid}, 32'd0);
    chk("flush_MemWrite", {31'b0, MemMemWrite}, 32'd0);
    chk("flush_Redirect", {31'b0, Redirect}, 32'd0);

    // JAL at the top of the address space: target and link both wrap
    clr(); ExValid = 1; Jump = 1; pc = 32'hFFFF_FFFC; ImmGenOut = 32'h8;
    step();
    chk("wrap_Target", BranchTarget, 32'h4);
    chk("wrap_Link", MemALUResult, 32'h0);
    chk("wrap_Count", TakenCount, 32'd4);

    // remaining branch conditions
    for (int i = 0; i < 8; i++) begin
      clr(); ExValid = 1; Branch = (i != 7);
      {Funct3, Zero, Less} = br_tab[i][5:1];
      if (i == 7) Funct3 = 3'd0;
      step();
      chk("br_Redirect", {31'b0, Redirect}, {31'b0, br_tab[i][0]});
    end
    chk("pre_rst_Count", TakenCount, 32'd7);

    // asynchronous reset while an instruction is held
    clr(); ExValid = 1; ALUResult = 32'h77; RegWrite = 1; Rd = 9;
    step();
    Stall = 1;
    step();
    #2 rst = 1;
    #1;
    chk("arst_outputs", {31'b0, |{MemValid, MemALUResult, MemWriteData, MemRd,
        MemRegWrite, MemMemRead, MemMemWrite, MemMemToReg, Redirect,
        BranchTarget, TargetMisaligned}}, 32'd0);
    chk("arst_Count", TakenCount, 32'd0);
    step();
    rst = 0;
    step();
    chk("post_rst_stall_Valid", {31'b0, MemValid}, 32'd0);
    Stall = 0; ALUResult = 32'h11; Rd = 4;
    step();
    chk("post_rst_alu", MemALUResult, 32'h11);
    chk("post_rst_Valid", {31'b0, MemValid}, 32'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
REQ-002 The block SHALL have these inputs from the EX stage:
- Stall  in  1  hold all state
- Flush  in  1  insert bubble
- ExValid  in  1  EX slot holds a real instruction
- ALUResult  in  32  ALU output
- Zero  in  1  ALU output
- Less  in  1  ALU output
- ReadData2  in  32  store data
- pc  in  32  EX-stage instruction address
- ImmGenOut  in  32  immediate
- Branch  in  1  conditional branch
- Jump  in  1  JAL/JALR
- Jalr  in  1  JALR (valid only with Jump)
- Funct3  in  3  branch condition
- MemRead  in  1  control
- MemWrite  in  1  control
- MemToReg  in  1  control
- RegWrite  in  1  control
- Rd  in  5  destination register
REQ-003 The block SHALL have these outputs:
- MemValid  out  1  MEM slot holds a real instruction
- MemALUResult  out  32  registered result
- MemWriteData  out  32  registered store data
- MemRd  out  5  registered destination
- MemRegWrite, MemMemRead, MemMemWrite, MemMemToReg  out  1 each  registered controls
- Redirect  out  1  one-cycle PC redirect pulse
- BranchTarget  out  32  redirect address
- TargetMisaligned  out  1  BranchTarget[1:0] nonzero on redirect
- TakenCount  out  32  count of redirects issued

Function
REQ-004 Taken SHALL be computed combinationally in EX as: Jump → 1; Branch with Funct3 000 → Zero, 001 → ~Zero, 100 → Less, 101 → ~Less, 110 → Less, 111 → ~Less, 010/011 → 0; otherwise → 0.
REQ-005 Less SHALL be used as delivered; the signed/unsigned compare selection is made upstream via ALUCtl.
REQ-006 The target SHALL be computed as: Jalr → {ALUResult[31:1],1'b0}; otherwise → pc+ImmGenOut (32-bit, wrap-around, carry discarded).
REQ-007 MemALUResult SHALL capture pc+4 (wrap at 2^32) when Jump=1, else ALUResult.
REQ-008 Each cycle, with Flush=0 and Stall=0, all registered outputs SHALL capture their EX inputs, and MemValid SHALL capture ExValid.
REQ-009 When ExValid=0, the block SHALL capture a bubble: MemValid=0, all Mem* controls 0, no redirect.
REQ-010 When Stall=1 and Flush=0, all registers SHALL hold, and Redirect SHALL be 0.
REQ-011 When Flush=1 (regardless of Stall), the block SHALL capture a bubble; Flush has priority over Stall.
REQ-012 Redirect SHALL be 1 for exactly the one cycle after a valid taken instruction is captured; it SHALL NOT reassert while that instruction is held by Stall.
REQ-013 BranchTarget and TargetMisaligned SHALL be registered together with the instruction and be meaningful only while Redirect=1.
REQ-014 TakenCount SHALL increment by 1 on each cycle in which Redirect=1, wrapping 0xFFFFFFFF→0.
REQ-015 Latency SHALL be exactly one cycle from EX inputs to Mem* outputs and to Redirect.
REQ-016 All outputs SHALL be driven by registers only, with no combinational input-to-output path.

Reset
REQ-017 While rst=1, all outputs SHALL be 0 immediately (asynchronous), including TakenCount and the redirect-pulse state.
REQ-018 Deassertion of rst SHALL take effect at the next clk edge; reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ALU op: ExValid=1, ALUResult=30, RegWrite=1, Rd=5 → next cycle MemValid=1, MemALUResult=30, MemRd=5, Redirect=0.
- BEQ: Branch=1, Funct3=000, Zero=1, pc=0x100, ImmGenOut=0x20 → Redirect=1 for one cycle, BranchTarget=0x120, TakenCount=1.
- BGE not taken: Funct3=101, Less=1 → Redirect=0; JALR with ALUResult=0x203 and pc=0x40 → BranchTarget=0x202, TargetMisaligned=1, MemALUResult=0x44.
- Stall: capture a taken JAL, then hold Stall=1 for 3 cycles → Redirect high only in the first cycle, outputs constant, TakenCount incremented once.
- Flush with Stall both asserted on a valid store → MemValid=0, MemMemWrite=0, Redirect=0.
- rst asserted mid-operation with TakenCount=7 → all outputs 0 without waiting for a clk edge.
